// File: rtl/bus_memory_if.sv
// bus_memory_if: CPU address/data bus bundle between a CPU master and bus_memory.
interface bus_memory_if;
  logic [63:0] i_ad;
  logic [7:0] i_tag;
  logic i_astb;
  logic i_atomic;
  logic i_rd;
  logic i_wr;
  logic [63:0] o_data;
  logic [7:0] o_tag;
  logic o_valid;
  modport master (output i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, input o_data, o_tag, o_valid);
  modport slave (input i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, output o_data, o_tag, o_valid);
endinterface

// File: rtl/bus_memory.sv
// bus_memory: tagged 72-bit word memory behind a strobed CPU bus with atomic read-modify-write.
// Define BUS_MEMORY_ERRFLAG_EN to add the sticky o_err protocol-error port.
module bus_memory #(
  parameter int ADDR_W = 20,
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic reset,
  bus_memory_if.slave bus
`ifdef BUS_MEMORY_ERRFLAG_EN
  , output logic o_err
`endif
);
  typedef enum logic [1:0] {IDLE, ADDR, RDWAIT, LOCK} state_t;
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);
  logic [71:0] mem [2**ADDR_W];
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic lock_q, lock_d;
  logic [1:0] cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic [7:0] tag_q, tag_d;
  logic valid_q, valid_d;
  logic wr_en;
  logic [71:0] rd_word;
  always_comb begin
    rd_word = mem[addr_q];
    state_d = state_q;
    addr_d = addr_q;
    lock_d = lock_q;
    cnt_d = cnt_q;
    data_d = data_q;
    tag_d = tag_q;
    valid_d = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      IDLE, ADDR: begin
        if (bus.i_astb) begin
          addr_d = bus.i_ad[ADDR_W-1:0];
          lock_d = bus.i_atomic;
          state_d = ADDR;
        end
        if (bus.i_rd && (bus.i_astb || state_q == ADDR)) begin
          state_d = RDWAIT;
          cnt_d = LAT_M1;
        end
        wr_en = state_q == ADDR && bus.i_wr && !bus.i_astb && !bus.i_rd;
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          data_d = rd_word[63:0];
          tag_d = rd_word[71:64];
          valid_d = 1'b1;
          state_d = lock_q ? LOCK : ADDR;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        wr_en = bus.i_wr && !bus.i_astb && !bus.i_rd;
        lock_d = wr_en ? 1'b0 : lock_q;
        state_d = wr_en ? ADDR : LOCK;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      lock_q <= 1'b0;
      cnt_q <= 2'd0;
      data_q <= '0;
      tag_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      lock_q <= lock_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      tag_q <= tag_d;
      valid_q <= valid_d;
    end
  end
  // The array has no reset; a write is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[addr_q] <= {bus.i_tag, bus.i_ad};
  end
  assign bus.o_data = data_q;
  assign bus.o_tag = tag_q;
  assign bus.o_valid = valid_q;
`ifdef BUS_MEMORY_ERRFLAG_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q | (state_q == RDWAIT ? (bus.i_astb | bus.i_rd | bus.i_wr)
                   : state_q == LOCK ? (bus.i_astb | bus.i_rd)
                   : (bus.i_wr && (bus.i_astb || bus.i_rd || state_q == IDLE))
                     || (bus.i_rd && !bus.i_astb && state_q == IDLE));
  end
  always_ff @(posedge clk) begin
    err_q <= reset ? 1'b0 : err_d;
  end
  assign o_err = err_q;
`endif
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: scoreboard bench for bus_memory with READ_LAT=3 and ADDR_W=20.
module tb_bus_memory;
  localparam int LAT = 3;
  typedef struct {
    logic [71:0] d;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];
  logic [71:0] mem_m [int];
  logic [19:0] a_m = '0;
  logic [63:0] rdat [6];
  logic [19:0] radr [6];
  bus_memory_if bus ();
`ifdef BUS_MEMORY_ERRFLAG_EN
  logic o_err;
`endif
  bus_memory #(.ADDR_W(20), .READ_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef BUS_MEMORY_ERRFLAG_EN
    , .o_err(o_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_err(input logic e);
`ifdef BUS_MEMORY_ERRFLAG_EN
    check("o_err", 64'(o_err), 64'(e));
`endif
  endtask
  function automatic logic [71:0] mem_rd(input logic [19:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 72'h0;
  endfunction
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (q.size() == 0) check("spurious_valid", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = q.pop_front();
        check("rd_data", bus.o_data, e.d[63:0]);
        check("rd_tag", 64'(bus.o_tag), 64'(e.d[71:64]));
        check("rd_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  task automatic drive(input logic astb, input logic at, input logic rd, input logic wr,
                       input logic [63:0] ad, input logic [7:0] tg);
    @(negedge clk);
    bus.i_astb = astb;
    bus.i_atomic = at;
    bus.i_rd = rd;
    bus.i_wr = wr;
    bus.i_ad = ad;
    bus.i_tag = tg;
  endtask
  task automatic nop(input int n);
    repeat (n) drive('0, '0, '0, '0, '0, '0);
  endtask
  task automatic push();
    q.push_back('{mem_rd(a_m), cyc + 1 + LAT});
  endtask
  task automatic m_astb(input logic [63:0] ad, input logic at, input logic rd);
    drive(1'b1, at, rd, 1'b0, ad, 8'h0);
    a_m = ad[19:0];
    if (rd) push();
  endtask
  task automatic m_wr(input logic [63:0] d, input logic [7:0] t);
    drive(1'b0, 1'b0, 1'b0, 1'b1, d, t);
    mem_m[int'(a_m)] = {t, d};
  endtask
  task automatic m_rd();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    push();
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) nop(1);
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
    nop(1);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    nop(1);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_astb = 1'b0;
    bus.i_atomic = 1'b0;
    bus.i_rd = 1'b0;
    bus.i_wr = 1'b0;
    bus.i_ad = '0;
    bus.i_tag = '0;
    reset_dut();
    check("rst_valid", 64'(bus.o_valid), 64'(0));
    check("rst_data", bus.o_data, 64'h0);
    check("rst_tag", 64'(bus.o_tag), 64'(0));
    chk_err(1'b0);
    m_astb(64'h12345, 1'b0, 1'b0);
    m_wr(64'h0123456789ABCDEF, 8'h3C);
    m_astb(64'h12345, 1'b0, 1'b0);
    m_rd();
    drain();
    nop(5);
    check("hold_data", bus.o_data, 64'h0123456789ABCDEF);
    check("hold_tag", 64'(bus.o_tag), 64'(8'h3C));
    for (int i = 0; i < 6; i++) begin
      radr[i] = 20'($urandom_range(0, 20'hFFFFF));
      rdat[i] = {$urandom, $urandom};
      m_astb(64'(radr[i]), 1'b0, 1'b0);
      m_wr(rdat[i], 8'(i * 17 + 1));
    end
    for (int i = 0; i < 6; i++) begin
      m_astb(64'(radr[i]), 1'b0, 1'b1);
      drain();
    end
    m_astb(64'h2222, 1'b0, 1'b0);
    m_wr(64'hAAAA_5555_0000_FFFF, 8'h81);
    m_rd();
    drain();
    m_wr(64'hBBBB_0000_1111_2222, 8'h42);
    m_rd();
    drain();
    m_astb(64'h10, 1'b0, 1'b0);
    m_wr(64'd5, 8'h0);
    m_astb(64'h10, 1'b1, 1'b1);
    drain();
    check("atomic_first", bus.o_data, 64'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h20, 8'h0);
    nop(1);
    chk_err(1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    nop(6);
    m_wr(64'd6, 8'h0);
    m_rd();
    drain();
    check("atomic_second", bus.o_data, 64'd6);
    m_astb(64'hFFFF_FFFF_FFF0_0007, 1'b0, 1'b0);
    m_wr(64'hDEAD_BEEF_CAFE_F00D, 8'hA5);
    m_astb(64'h7, 1'b0, 1'b1);
    drain();
    check("wrap_data", bus.o_data, 64'hDEAD_BEEF_CAFE_F00D);
    reset_dut();
    chk_err(1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    nop(1);
    chk_err(1'b1);
    nop(5);
    reset_dut();
    chk_err(1'b0);
    m_astb(64'h2222, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0BAD, 8'hEE);
    drain();
    chk_err(1'b1);
    m_rd();
    drain();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h0BAD, 8'hEE);
    push();
    drain();
    m_rd();
    drain();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h10, 8'hEE);
    a_m = 20'h10;
    m_rd();
    drain();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h7, 8'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0BAD, 8'hEE);
    @(negedge clk);
    reset = 1'b0;
    bus.i_wr = 1'b0;
    m_astb(64'h7, 1'b0, 1'b1);
    drain();
    m_astb(64'h2222, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    @(negedge clk);
    reset = 1'b1;
    bus.i_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    nop(6);
    check("abort_data", bus.o_data, 64'h0);
    check("abort_tag", 64'(bus.o_tag), 64'(0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    nop(6);
    check("idle_rd_data", bus.o_data, 64'h0);
    check("idle_rd_valid", 64'(bus.o_valid), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
